// File: rtl/bus_arbiter.sv
// Merges the core's fetch and data ports onto one memory port, one transaction at a time; 2-cycle minimum latency.
// Requesters hold valid until data_ok, memory stalls REQ via addr_ok; data has priority, fetch wins after two passes.
module bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_addr_ok,
  input  logic              mresp_data_ok,
  input  logic [DATA_W-1:0] mresp_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [1:0] STARVE_MAX = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [7:0]        strobe;
    logic [DATA_W-1:0] data;
  } mreq_t;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] owner;
  logic [1:0] starve_cnt;
  mreq_t      lat;
  logic       grant_i;
  logic       grant_d;
  logic       capture;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        // Data wins unless the fetch has already been passed over twice.
        if (dreq_valid && !(ireq_valid && starve_cnt == STARVE_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = S_REQ;
        end else if (ireq_valid) begin
          grant_i   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mresp_addr_ok) begin
          if (mresp_data_ok) begin
            capture   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mresp_data_ok) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      owner         <= OWN_NONE;
      starve_cnt    <= 2'd0;
      lat           <= '0;
      mreq_valid    <= 1'b0;
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= '0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= '0;
    end else begin
      state      <= state_nxt;
      mreq_valid <= (state_nxt == S_REQ);

      if (grant_d) begin
        owner      <= OWN_D;
        lat.addr   <= dreq_addr;
        lat.size   <= dreq_size;
        lat.strobe <= dreq_strobe;
        lat.data   <= dreq_data;
        if (!ireq_valid) begin
          starve_cnt <= 2'd0;
        end else if (starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 2'd1;
        end
      end else if (grant_i) begin
        owner      <= OWN_I;
        lat.addr   <= ireq_addr;
        lat.size   <= 3'd2;
        lat.strobe <= 8'h00;
        lat.data   <= '0;
        starve_cnt <= 2'd0;
      end

      // Pulses are launched on the capture edge, so they land exactly in DONE.
      iresp_addr_ok <= capture && (owner == OWN_I);
      iresp_data_ok <= capture && (owner == OWN_I);
      dresp_addr_ok <= capture && (owner == OWN_D);
      dresp_data_ok <= capture && (owner == OWN_D);

      if (capture && owner == OWN_D) begin
        dresp_data <= mresp_data;
      end
      if (capture && owner == OWN_I) begin
        iresp_data <= lat.addr[2] ? mresp_data[DATA_W-1 -: 32] : mresp_data[31:0];
      end
    end
  end

  assign mreq_addr   = lat.addr;
  assign mreq_size   = lat.size;
  assign mreq_strobe = lat.strobe;
  assign mreq_data   = lat.data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_addr_ok;
  logic        mresp_data_ok;
  logic [63:0] mresp_data;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [2:0]  dsz;
    logic [7:0]  dstb;
    logic [63:0] dd;
    logic        mao;
    logic        mdo;
    logic [63:0] md;
    logic        e_mv;
    logic [63:0] e_ma;
    logic [2:0]  e_msz;
    logic [7:0]  e_mstb;
    logic        e_iok;
    logic        e_dok;
    logic [31:0] e_id;
    logic [63:0] e_dd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ireq_valid    = 1'b0;
    ireq_addr     = 64'h0;
    dreq_valid    = 1'b0;
    dreq_addr     = 64'h0;
    dreq_size     = 3'd0;
    dreq_strobe   = 8'h00;
    dreq_data     = 64'h0;
    mresp_addr_ok = 1'b0;
    mresp_data_ok = 1'b0;
    mresp_data    = 64'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic apply_vec(input vec_t v);
    ireq_valid    = v.iv;
    ireq_addr     = v.ia;
    dreq_valid    = v.dv;
    dreq_addr     = v.da;
    dreq_size     = v.dsz;
    dreq_strobe   = v.dstb;
    dreq_data     = v.dd;
    mresp_addr_ok = v.mao;
    mresp_data_ok = v.mdo;
    mresp_data    = v.md;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mreq_valid"},  mreq_valid, 0);
    check({tag, " mreq_addr"},   mreq_addr, 0);
    check({tag, " mreq_size"},   mreq_size, 0);
    check({tag, " mreq_strobe"}, mreq_strobe, 0);
    check({tag, " mreq_data"},   mreq_data, 0);
    check({tag, " iresp_data"},  iresp_data, 0);
    check({tag, " dresp_data"},  dresp_data, 0);
    check({tag, " resp pulses"}, {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 0);
  endtask

  initial begin
    int mv;
    int dp;
    int ip;
    int pulse_c;
    int ng;
    logic got_d[6];

    clk = 1'b0;
    rst = 1'b1;
    clear_inputs();
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // One row per cycle: inputs held across the edge, outputs expected just after it.
    vecs[0] = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b1, 64'h8000_0004, 3'd2, 8'h00, 1'b0, 1'b0, 32'h0, 64'h0};
    vecs[1] = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 1'b1, 64'h1111_2222_3333_4444,
                1'b0, 64'h8000_0004, 3'd2, 8'h00, 1'b1, 1'b0, 32'h1111_2222, 64'h0};
    vecs[2] = '{1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h8000_0004, 3'd2, 8'h00, 1'b0, 1'b0, 32'h1111_2222, 64'h0};
    vecs[3] = '{1'b1, 64'h8000_0008, 1'b1, 64'h200, 3'd3, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b1, 64'h200, 3'd3, 8'h00, 1'b0, 1'b0, 32'h1111_2222, 64'h0};
    vecs[4] = '{1'b1, 64'h8000_0008, 1'b1, 64'h200, 3'd3, 8'h00, 64'h0, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD,
                1'b0, 64'h200, 3'd3, 8'h00, 1'b0, 1'b1, 32'h1111_2222, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[5] = '{1'b1, 64'h8000_0008, 1'b1, 64'h200, 3'd3, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h200, 3'd3, 8'h00, 1'b0, 1'b0, 32'h1111_2222, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[6] = '{1'b1, 64'h8000_0008, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b1, 64'h8000_0008, 3'd2, 8'h00, 1'b0, 1'b0, 32'h1111_2222, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[7] = '{1'b1, 64'h8000_0008, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 1'b1, 64'h5555_6666_7777_8888,
                1'b0, 64'h8000_0008, 3'd2, 8'h00, 1'b1, 1'b0, 32'h7777_8888, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[8] = '{1'b1, 64'h8000_0008, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b0, 64'h8000_0008, 3'd2, 8'h00, 1'b0, 1'b0, 32'h7777_8888, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[9] = '{1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b0, 64'h8000_0008, 3'd2, 8'h00, 1'b0, 1'b0, 32'h7777_8888, 64'hAAAA_BBBB_CCCC_DDDD};

    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i]);
      tick();
      check($sformatf("v%0d mreq_valid", i),    mreq_valid, vecs[i].e_mv);
      check($sformatf("v%0d mreq_addr", i),     mreq_addr, vecs[i].e_ma);
      check($sformatf("v%0d mreq_size", i),     mreq_size, vecs[i].e_msz);
      check($sformatf("v%0d mreq_strobe", i),   mreq_strobe, vecs[i].e_mstb);
      check($sformatf("v%0d iresp_addr_ok", i), iresp_addr_ok, vecs[i].e_iok);
      check($sformatf("v%0d iresp_data_ok", i), iresp_data_ok, vecs[i].e_iok);
      check($sformatf("v%0d dresp_addr_ok", i), dresp_addr_ok, vecs[i].e_dok);
      check($sformatf("v%0d dresp_data_ok", i), dresp_data_ok, vecs[i].e_dok);
      check($sformatf("v%0d iresp_data", i),    iresp_data, vecs[i].e_id);
      check($sformatf("v%0d dresp_data", i),    dresp_data, vecs[i].e_dd);
    end

    // Data write: addr_ok in the 4th REQ cycle, data_ok 4 cycles after that.
    apply_reset();
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h100;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_data   = 64'hDEAD_BEEF;
    tick();
    check("wr mreq_data", mreq_data, 64'hDEAD_BEEF);
    check("wr mreq_strobe", mreq_strobe, 8'hFF);
    mv = 0; dp = 0; ip = 0; pulse_c = -1;
    for (int c = 1; c <= 12; c++) begin
      if (mreq_valid) mv++;
      if (dresp_data_ok) begin dp++; pulse_c = c; end
      if (iresp_addr_ok || iresp_data_ok) ip++;
      mresp_addr_ok = (c == 4);
      mresp_data_ok = (c == 8);
      mresp_data    = (c == 8) ? 64'h0123_4567_89AB_CDEF : 64'h0;
      if (dp != 0) dreq_valid = 1'b0;
      tick();
    end
    check("wr mreq_valid cycles", mv, 4);
    check("wr dresp pulses", dp, 1);
    check("wr dresp pulse cycle", pulse_c, 9);
    check("wr iresp pulses", ip, 0);
    check("wr dresp_data", dresp_data, 64'h0123_4567_89AB_CDEF);

    // Fetch requester drops valid while its request is still in REQ.
    apply_reset();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0010;
    tick();
    mv = 0; ip = 0; pulse_c = -1;
    for (int c = 1; c <= 8; c++) begin
      if (mreq_valid) mv++;
      if (iresp_data_ok) begin ip++; pulse_c = c; end
      ireq_valid    = 1'b0;
      mresp_addr_ok = (c == 2);
      mresp_data_ok = (c == 2);
      mresp_data    = 64'h9999_AAAA_BBBB_CCCC;
      tick();
    end
    check("drop mreq_valid cycles", mv, 2);
    check("drop iresp pulses", ip, 1);
    check("drop pulse cycle", pulse_c, 3);
    check("drop iresp_data", iresp_data, 32'hBBBB_CCCC);

    // Both requesters held valid against a zero-wait memory.
    apply_reset();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0000;
    dreq_valid = 1'b1;
    dreq_addr  = 64'h300;
    dreq_size  = 3'd3;
    tick();
    ng = 0; dp = 0; ip = 0;
    for (int k = 0; k < 6; k++) got_d[k] = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      mresp_addr_ok = 1'b0;
      mresp_data_ok = 1'b0;
      if (mreq_valid) begin
        if (ng < 6) got_d[ng] = (mreq_addr == 64'h300);
        ng++;
        mresp_addr_ok = 1'b1;
        mresp_data_ok = 1'b1;
        mresp_data    = 64'h1234_5678_9ABC_DEF0;
      end
      if (dresp_data_ok) dp++;
      if (iresp_data_ok) ip++;
      if (c == 17) begin
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
      end
      tick();
    end
    check("starve grant count", ng, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("starve grant %0d is data", k), got_d[k], (k % 3) != 2);
    end
    check("starve dresp pulses", dp, 4);
    check("starve iresp pulses", ip, 2);
    check("starve iresp_data", iresp_data, 32'h9ABC_DEF0);

    // Asynchronous reset while the transaction sits in WAIT.
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h400;
    dreq_size   = 3'd3;
    dreq_strobe = 8'h0F;
    dreq_data   = 64'h55;
    mresp_data  = 64'h0;
    tick();
    check("rw mreq_valid REQ", mreq_valid, 1);
    check("rw mreq_addr", mreq_addr, 64'h400);
    mresp_addr_ok = 1'b1;
    tick();
    check("rw mreq_valid WAIT", mreq_valid, 0);
    mresp_addr_ok = 1'b0;
    #3 rst = 1'b0;
    #1 check_all_zero("rw async");
    dreq_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    mresp_data_ok = 1'b1;
    mresp_data    = 64'hCAFE;
    tick();
    check("rw late data_ok pulses", {iresp_data_ok, dresp_data_ok, dresp_addr_ok}, 0);
    check("rw late mreq_valid", mreq_valid, 0);
    check("rw late dresp_data", dresp_data, 0);
    mresp_data_ok = 1'b0;
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h408;
    dreq_strobe = 8'h00;
    tick();
    check("rw next mreq_valid", mreq_valid, 1);
    check("rw next mreq_addr", mreq_addr, 64'h408);
    mresp_addr_ok = 1'b1;
    mresp_data_ok = 1'b1;
    mresp_data    = 64'h0BAD_F00D;
    tick();
    check("rw next dresp pulse", {dresp_addr_ok, dresp_data_ok}, 2'b11);
    check("rw next dresp_data", dresp_data, 64'h0BAD_F00D);
    dreq_valid    = 1'b0;
    mresp_addr_ok = 1'b0;
    mresp_data_ok = 1'b0;
    tick();
    check("rw next pulse ends", dresp_data_ok, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Sits directly downstream of the CPU core.
- Merges the core's instruction-fetch port and data port onto one shared memory port, so one memory model or cache serves both.
- Runs one transaction at a time through a 4-state FSM. Data has fixed priority, with an anti-starvation guard for fetches.
- Latches each granted request and returns the response to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 64, address width of all ports
- DATA_W, 64, shared memory data width; instruction width is fixed at 32

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ireq_valid  in  1  fetch request pending
- ireq_addr  in  ADDR_W  fetch address, 4-byte aligned
- iresp_addr_ok  out  1  fetch accepted (pulse)
- iresp_data_ok  out  1  fetch data valid (pulse)
- iresp_data  out  32  fetched instruction
- dreq_valid  in  1  data request pending
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  log2 bytes (0..3)
- dreq_strobe  in  8  byte write enables; 0 means read
- dreq_data  in  DATA_W  write data
- dresp_addr_ok  out  1  data request accepted (pulse)
- dresp_data_ok  out  1  data response valid (pulse)
- dresp_data  out  DATA_W  read data
- mreq_valid  out  1  shared-port request
- mreq_addr  out  ADDR_W  latched address
- mreq_size  out  3  latched size; fetch always 3'd2
- mreq_strobe  out  8  latched strobe; fetch always 0
- mreq_data  out  DATA_W  latched write data
- mresp_addr_ok  in  1  memory accepted request
- mresp_data_ok  in  1  memory completed
- mresp_data  in  DATA_W  memory read data

## Operation
FSM states: IDLE, REQ, WAIT, DONE.

- **Reset** (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including data buses.
  - Owner register = none; starvation counter = 0.
- **IDLE**: arbitrates on the sampled ireq_valid and dreq_valid.
  - Only one valid: grant it.
  - Both valid: grant data, unless the starvation counter is 2, in which case grant fetch.
  - On grant: latch addr/size/strobe/data and the owner (I or D); go to REQ.
  - Neither valid: stay in IDLE.
- **Starvation counter**:
  - Increments when data is granted while ireq_valid=1.
  - Clears on any fetch grant, and on a data grant with ireq_valid=0.
  - Saturates at 2.
- **REQ**: mreq_valid=1; mreq_* carry the latched values and stay stable.
  - mresp_addr_ok=1 and mresp_data_ok=1 together: capture mresp_data, go to DONE.
  - mresp_addr_ok=1 only: go to WAIT.
  - Otherwise stay in REQ.
- **WAIT**: mreq_valid=0.
  - On mresp_data_ok: capture mresp_data, go to DONE.
  - mresp_data_ok arriving in the same cycle as mresp_addr_ok is handled by REQ, not WAIT.
- **DONE**: the owner's addr_ok and data_ok are both 1 for exactly this cycle.
  - The non-owner's response signals stay 0.
  - Next state is IDLE, unconditionally.
- **Response data** (registered, held until the next capture):
  - Data owner: dresp_data = captured word.
  - Fetch owner: iresp_data = captured[63:32] if latched addr[2]=1, else captured[31:0].
- **Requester behaviour**: requesters hold valid and payload until they see data_ok, then drop valid on the next cycle.
  - Dropping valid mid-transaction does not abort it. The transaction completes and the DONE pulse is still issued.
- Memory response pulses arriving in IDLE or DONE are ignored.

## Timing
- Minimum latency is 2 cycles, from valid being sampled in IDLE (cycle 0):
  - mreq_valid in cycle 1.
  - If memory returns addr_ok+data_ok in cycle 1, the DONE pulse is in cycle 2.
- General latency: 2 + (cycles REQ waits for addr_ok) + (cycles in WAIT).
- Back-to-back transactions: the next grant is sampled in the IDLE cycle after DONE. Minimum issue interval is 3 cycles.
- Every response output is registered; there is no combinational path from memory inputs to CPU outputs.
- mreq_* are registered and change only on a grant.

## Test plan
- **Single fetch:** ireq addr 0x8000_0004; memory returns 0x1111_2222_3333_4444 with addr_ok+data_ok in the first REQ cycle. Required:
  - iresp_data = 0x1111_2222.
  - iresp_addr_ok and iresp_data_ok pulse in cycle 2.
  - mreq_size = 2, mreq_strobe = 0.
- **Data write with stalls:** dreq addr 0x100, strobe 0xFF, data 0xDEAD_BEEF; addr_ok after 3 cycles, data_ok 4 cycles later. Required:
  - mreq_valid high for exactly 4 cycles.
  - Single dresp pulse; iresp stays 0.
- **Simultaneous requests:** both valid in IDLE. Required:
  - Data is served first, then the fetch.
  - Order D, I; fetch pulses 3 cycles after the data pulses when memory is zero-wait.
- **Starvation guard:** dreq_valid re-asserted continuously alongside a pending fetch. Required:
  - Grant sequence D, D, I, D, D, I.
- **Async reset mid-WAIT:** assert rst=0 between clock edges. Required:
  - All outputs are 0 immediately.
  - State is IDLE; a later mresp_data_ok produces no response pulse.
  - The next request completes normally.
- **Requester drops valid in REQ:** Required:
  - The transaction still completes and the DONE pulse fires.
  - No second grant is issued.
